// File: rtl/game_state_ctrl.sv
// Game-mode sequencer for the VGA runner: start screen, run with lives/grace, game over.
// Define START_BLINK_EN to blink the start-screen text on the IDLE screen.
module game_state_ctrl #(
    parameter int LIVES        = 3,
    parameter int BLINK_FRAMES = 30,
    parameter int INV_FRAMES   = 60,
    parameter int OVER_FRAMES  = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       hit,
    output logic       start_en,
    output logic       run_en,
    output logic       over_en,
    output logic       invuln,
    output logic [1:0] lives
);

    localparam int IW = (INV_FRAMES > 1) ? $clog2(INV_FRAMES) : 1;
    localparam int OW = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;
    localparam logic [IW-1:0] INV_LAST  = IW'(INV_FRAMES - 1);
    localparam logic [OW-1:0] OVER_LAST = OW'(OVER_FRAMES - 1);
    localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        state;
    logic          btn_prev;
    logic [IW-1:0] inv_cnt;
    logic [OW-1:0] over_cnt;
    logic          press;

`ifdef START_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    logic [BW-1:0] blink_cnt;
    logic          phase;
`endif

    assign press = btn_start & ~btn_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            btn_prev <= 1'b1;
            start_en <= 1'b1;
            run_en   <= 1'b0;
            over_en  <= 1'b0;
            invuln   <= 1'b0;
            lives    <= LIVES_INIT;
            inv_cnt  <= '0;
            over_cnt <= '0;
`ifdef START_BLINK_EN
            blink_cnt <= '0;
            phase     <= 1'b1;
`endif
        end else begin
            btn_prev <= btn_start;
            unique case (state)
                IDLE: begin
                    // A press wins over any hit arriving in the same cycle
                    if (press) begin
                        state    <= RUN;
                        start_en <= 1'b0;
                        run_en   <= 1'b1;
                        lives    <= LIVES_INIT;
                        invuln   <= 1'b0;
                        inv_cnt  <= '0;
                    end
`ifdef START_BLINK_EN
                    else if (frame_tick) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            phase     <= ~phase;
                            start_en  <= ~phase;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
`endif
                end
                RUN: begin
                    if (hit && !invuln) begin
                        if (lives == 2'd1) begin
                            lives    <= 2'd0;
                            state    <= OVER;
                            run_en   <= 1'b0;
                            over_en  <= 1'b1;
                            over_cnt <= '0;
                        end else begin
                            lives   <= lives - 2'd1;
                            invuln  <= 1'b1;
                            inv_cnt <= '0;
                        end
                    end else if (invuln && frame_tick) begin
                        if (inv_cnt == INV_LAST) begin
                            invuln  <= 1'b0;
                            inv_cnt <= '0;
                        end else begin
                            inv_cnt <= inv_cnt + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (frame_tick) begin
                        if (over_cnt == OVER_LAST) begin
                            state    <= IDLE;
                            over_en  <= 1'b0;
                            start_en <= 1'b1;
                            over_cnt <= '0;
`ifdef START_BLINK_EN
                            phase     <= 1'b1;
                            blink_cnt <= '0;
`endif
                        end else begin
                            over_cnt <= over_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    start_en <= 1'b1;
                    run_en   <= 1'b0;
                    over_en  <= 1'b0;
                    invuln   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with default parameters.
// Honours START_BLINK_EN to pick the expected start-screen blink behaviour.
module tb_game_state_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       btn_start;
    logic       hit;
    logic       start_en;
    logic       run_en;
    logic       over_en;
    logic       invuln;
    logic [1:0] lives;

    int tests;
    int fails;

    game_state_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .hit        (hit),
        .start_en   (start_en),
        .run_en     (run_en),
        .over_en    (over_en),
        .invuln     (invuln),
        .lives      (lives)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic s, input logic r,
                           input logic o, input logic i, input logic [1:0] l);
        chk({tag, ".start_en"}, {7'd0, start_en}, {7'd0, s});
        chk({tag, ".run_en"},   {7'd0, run_en},   {7'd0, r});
        chk({tag, ".over_en"},  {7'd0, over_en},  {7'd0, o});
        chk({tag, ".invuln"},   {7'd0, invuln},   {7'd0, i});
        chk({tag, ".lives"},    {6'd0, lives},    {6'd0, l});
    endtask

    logic blink_on;

    initial begin
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        frame_tick = 1'b0;
        btn_start  = 1'b1;
        hit        = 1'b0;
`ifdef START_BLINK_EN
        blink_on = 1'b1;
`else
        blink_on = 1'b0;
`endif
        step();
        step();
        chk_all("reset", 1, 0, 0, 0, 3);
        reset = 1'b0;
        step();

        // button held through reset must not start a game
        ticks(5);
        chk_all("held_btn", 1, 0, 0, 0, 3);

        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        chk("pre_press.run_en", {7'd0, run_en}, 8'd0);
        step();
        chk_all("press", 0, 1, 0, 0, 3);

        hit = 1'b1;
        step();
        hit = 1'b0;
        chk_all("hit1", 0, 1, 0, 1, 2);

        ticks(10);
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk_all("hit_in_grace", 0, 1, 0, 1, 2);

        ticks(49);
        chk("grace59.invuln", {7'd0, invuln}, 8'd1);
        ticks(1);
        chk("grace60.invuln", {7'd0, invuln}, 8'd0);

        // hit coinciding with a frame tick restarts grace from zero
        hit        = 1'b1;
        frame_tick = 1'b1;
        step();
        hit        = 1'b0;
        frame_tick = 1'b0;
        chk_all("hit_tick", 0, 1, 0, 1, 1);
        step();
        ticks(59);
        chk("hit_tick59.invuln", {7'd0, invuln}, 8'd1);
        ticks(1);
        chk("hit_tick60.invuln", {7'd0, invuln}, 8'd0);

        hit = 1'b1;
        step();
        hit = 1'b0;
        chk_all("fatal_hit", 0, 0, 1, 0, 0);

        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        step();
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk_all("over_press_hit", 0, 0, 1, 0, 0);

        ticks(119);
        chk_all("over119", 0, 0, 1, 0, 0);
        ticks(1);
        chk_all("over120", 1, 0, 0, 0, 0);

        ticks(30);
        chk("idle30.start_en", {7'd0, start_en}, {7'd0, ~blink_on});
        ticks(30);
        chk("idle60.start_en", {7'd0, start_en}, 8'd1);
        ticks(40);
        chk("idle100.start_en", {7'd0, start_en}, {7'd0, ~blink_on});
        chk("idle100.run_en", {7'd0, run_en}, 8'd0);

        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        step();
        chk_all("game2", 0, 1, 0, 0, 3);
        hit = 1'b1;
        step();
        hit = 1'b0;
        ticks(60);
        chk_all("game2_grace", 0, 1, 0, 0, 2);
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk_all("game2_hit", 0, 1, 0, 1, 1);

        reset = 1'b1;
        step();
        chk_all("mid_reset", 1, 0, 0, 0, 3);
        reset = 1'b0;
        btn_start = 1'b0;
        step();

        hit = 1'b1;
        step();
        hit = 1'b0;
        chk_all("idle_hit", 1, 0, 0, 0, 3);

        btn_start = 1'b1;
        hit       = 1'b1;
        step();
        hit = 1'b0;
        chk_all("press_hit", 0, 1, 0, 0, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
